// File: rtl/uart_alu_interface_pkg.sv
// ============================================================================
// Module : uart_alu_interface_pkg
// Brief  : Shared state encoding, ALU opcodes and width defaults.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_alu_interface_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  localparam logic [2:0] ST_WAIT_A  = 3'd0;
  localparam logic [2:0] ST_WAIT_B  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP = 3'd2;
  localparam logic [2:0] ST_COMPUTE = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;
  localparam logic [2:0] ST_WAIT_TX = 3'd5;

  typedef enum logic [2:0] {
    WAIT_A  = ST_WAIT_A,
    WAIT_B  = ST_WAIT_B,
    WAIT_OP = ST_WAIT_OP,
    COMPUTE = ST_COMPUTE,
    SEND    = ST_SEND,
    WAIT_TX = ST_WAIT_TX
  } state_t;

  localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'd32;
  localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'd34;
  localparam logic [NB_OP_DEF-1:0] OP_AND = 6'd36;
  localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'd37;
  localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'd38;
  localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'd3;
  localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'd2;
  localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'd39;

endpackage

`default_nettype wire

// File: rtl/uart_alu_interface.sv
// ============================================================================
// Module : uart_alu_interface
// Brief  : Collects A, B, opcode from UART RX, drives the ALU, sends result.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_alu_interface
  import uart_alu_interface_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_data_a,
  output logic [NB_DATA-1:0] o_alu_data_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_rx_overrun
);

  state_t             r_state;
  logic [NB_DATA-1:0] r_data_a;
  logic [NB_DATA-1:0] r_data_b;
  logic [NB_OP-1:0]   r_op;
  logic [NB_DATA-1:0] r_tx_data;
  logic               r_tx_start;
  logic               r_busy;
  logic               r_rx_overrun;

  // Busy is registered alongside the state so it tracks COMPUTE/SEND/WAIT_TX
  // exactly without a decode path to the output.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= WAIT_A;
      r_data_a     <= '0;
      r_data_b     <= '0;
      r_op         <= '0;
      r_tx_data    <= '0;
      r_tx_start   <= 1'b0;
      r_busy       <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_tx_start   <= 1'b0;
      r_rx_overrun <= 1'b0;
      case (r_state)
        WAIT_A: begin
          if (i_rx_done) begin
            r_data_a <= i_rx_data;
            r_state  <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (i_rx_done) begin
            r_data_b <= i_rx_data;
            r_state  <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (i_rx_done) begin
            r_op    <= i_rx_data[NB_OP-1:0];
            r_state <= COMPUTE;
            r_busy  <= 1'b1;
          end
        end
        COMPUTE: begin
          r_tx_data    <= i_alu_result;
          r_tx_start   <= 1'b1;
          r_rx_overrun <= i_rx_done;
          r_state      <= SEND;
        end
        SEND: begin
          r_rx_overrun <= i_rx_done;
          r_state      <= WAIT_TX;
        end
        WAIT_TX: begin
          r_rx_overrun <= i_rx_done;
          if (i_tx_done) begin
            r_state <= WAIT_A;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= WAIT_A;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_alu_data_a = r_data_a;
  assign o_alu_data_b = r_data_b;
  assign o_alu_op     = r_op;
  assign o_tx_data    = r_tx_data;
  assign o_tx_start   = r_tx_start;
  assign o_busy       = r_busy;
  assign o_rx_overrun = r_rx_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_alu_interface.sv
// ============================================================================
// Module : tb_uart_alu_interface
// Brief  : Scoreboard bench with a behavioural ALU in the loop.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_alu_interface;
  import uart_alu_interface_pkg::*;

  logic       clk;
  logic       i_reset;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic       i_tx_done;
  logic [7:0] w_alu_result;
  logic [7:0] o_alu_data_a;
  logic [7:0] o_alu_data_b;
  logic [5:0] o_alu_op;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       o_busy;
  logic       o_rx_overrun;

  int         n_checks;
  int         n_errors;
  int         n_start;
  logic [7:0] exp_q[$];

  uart_alu_interface dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_rx_data    (i_rx_data),
    .i_rx_done    (i_rx_done),
    .i_tx_done    (i_tx_done),
    .i_alu_result (w_alu_result),
    .o_alu_data_a (o_alu_data_a),
    .o_alu_data_b (o_alu_data_b),
    .o_alu_op     (o_alu_op),
    .o_tx_data    (o_tx_data),
    .o_tx_start   (o_tx_start),
    .o_busy       (o_busy),
    .o_rx_overrun (o_rx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    w_alu_result = 8'h00;
    case (o_alu_op)
      OP_ADD:  w_alu_result = o_alu_data_a + o_alu_data_b;
      OP_SUB:  w_alu_result = o_alu_data_a - o_alu_data_b;
      OP_AND:  w_alu_result = o_alu_data_a & o_alu_data_b;
      OP_OR:   w_alu_result = o_alu_data_a | o_alu_data_b;
      OP_XOR:  w_alu_result = o_alu_data_a ^ o_alu_data_b;
      OP_SRA:  w_alu_result = $unsigned($signed(o_alu_data_a) >>> o_alu_data_b);
      OP_SRL:  w_alu_result = o_alu_data_a >> o_alu_data_b;
      OP_NOR:  w_alu_result = ~(o_alu_data_a | o_alu_data_b);
      default: w_alu_result = 8'h00;
    endcase
  end

  task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: each start pulse pops the result queued when the opcode went in.
  always @(negedge clk) begin
    if (o_tx_start === 1'b1) begin
      n_start++;
      if (exp_q.size() == 0) check_val("tx_unexpected", 16'd1, 16'd0);
      else                   check_val("tx_data", {8'h00, o_tx_data}, {8'h00, exp_q.pop_front()});
    end
  end

  task automatic rx_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge clk);
    i_rx_done = 1'b0;
  endtask

  task automatic tx_done_pulse();
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                        input logic [7:0] exp, input bit coincide);
    int starts_before;
    starts_before = n_start;
    exp_q.push_back(exp);
    rx_byte(a);
    rx_byte(b);
    rx_byte(opb);
    check_val("alu_a", {8'h00, o_alu_data_a}, {8'h00, a});
    check_val("alu_b", {8'h00, o_alu_data_b}, {8'h00, b});
    check_val("alu_op", {10'h000, o_alu_op}, {10'h000, opb[5:0]});
    check_val("start_early", {15'h0, o_tx_start}, 16'd0);
    check_val("busy_compute", {15'h0, o_busy}, 16'd1);
    @(negedge clk);
    check_val("start_pulse", {15'h0, o_tx_start}, 16'd1);
    if (coincide) i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    #1;
    check_val("start_len", {15'h0, o_tx_start}, 16'd0);
    check_val("busy_wait_tx", {15'h0, o_busy}, 16'd1);
    check_val("start_count", 16'(n_start - starts_before), 16'd1);
  endtask

  initial begin
    int starts_snap;
    n_checks  = 0;
    n_errors  = 0;
    n_start   = 0;
    i_reset   = 1'b0;
    i_rx_data = 8'h00;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_a", {8'h00, o_alu_data_a}, 16'd0);
    check_val("rst_tx_start", {15'h0, o_tx_start}, 16'd0);
    check_val("rst_busy", {15'h0, o_busy}, 16'd0);
    i_reset = 1'b1;
    @(negedge clk);

    run_op(8'h05, 8'h03, 8'd32, 8'h08, 1'b0);
    @(negedge clk);
    tx_done_pulse();
    check_val("busy_done", {15'h0, o_busy}, 16'd0);

    run_op(8'hF0, 8'h02, 8'd3,  8'hFC, 1'b0); tx_done_pulse();
    run_op(8'hF0, 8'h02, 8'd2,  8'h3C, 1'b0); tx_done_pulse();
    run_op(8'hF0, 8'h0F, 8'd39, 8'h00, 1'b0); tx_done_pulse();
    run_op(8'h01, 8'h02, 8'hE2, 8'hFF, 1'b0); tx_done_pulse();
    check_val("op_sub_masked", {10'h000, o_alu_op}, 16'd34);

    // Overrun in WAIT_TX, then simultaneous rx/tx done.
    run_op(8'h11, 8'h22, 8'd32, 8'h33, 1'b0);
    rx_byte(8'hAA);
    check_val("overrun_pulse", {15'h0, o_rx_overrun}, 16'd1);
    check_val("overrun_a_kept", {8'h00, o_alu_data_a}, 16'h0011);
    check_val("overrun_busy", {15'h0, o_busy}, 16'd1);
    @(negedge clk);
    check_val("overrun_once", {15'h0, o_rx_overrun}, 16'd0);
    i_rx_data = 8'h55;
    i_rx_done = 1'b1;
    tx_done_pulse();
    i_rx_done = 1'b0;
    check_val("sim_overrun", {15'h0, o_rx_overrun}, 16'd1);
    check_val("sim_busy", {15'h0, o_busy}, 16'd0);
    check_val("sim_a_kept", {8'h00, o_alu_data_a}, 16'h0011);
    run_op(8'h07, 8'h01, 8'd34, 8'h06, 1'b0); tx_done_pulse();

    // Reset between B and opcode.
    rx_byte(8'h09);
    rx_byte(8'h0A);
    i_reset = 1'b0;
    #1;
    check_val("mid_rst_a", {8'h00, o_alu_data_a}, 16'd0);
    check_val("mid_rst_b", {8'h00, o_alu_data_b}, 16'd0);
    check_val("mid_rst_op", {10'h000, o_alu_op}, 16'd0);
    check_val("mid_rst_tx", {8'h00, o_tx_data}, 16'd0);
    @(negedge clk);
    i_reset = 1'b1;
    starts_snap = n_start;
    repeat (5) @(negedge clk);
    #1;
    check_val("no_start_after_rst", 16'(n_start - starts_snap), 16'd0);
    run_op(8'h02, 8'h02, 8'd36, 8'h02, 1'b0); tx_done_pulse();

    // Coincident tx_done ignored; long wait in WAIT_TX.
    run_op(8'h03, 8'h04, 8'd38, 8'h07, 1'b1);
    starts_snap = n_start;
    repeat (50) @(negedge clk);
    #1;
    check_val("long_busy", {15'h0, o_busy}, 16'd1);
    check_val("long_no_start", 16'(n_start - starts_snap), 16'd0);
    @(negedge clk);
    tx_done_pulse();
    check_val("long_done", {15'h0, o_busy}, 16'd0);
    run_op(8'h0C, 8'h0A, 8'd37, 8'h0E, 1'b0); tx_done_pulse();

    check_val("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
- Sequencing stage between the UART receiver/transmitter pair and the ALU top.
- Collects three received bytes in order: operand A, operand B, opcode.
- Presents them as stable registered inputs to the combinational ALU, then captures the ALU result.
- Hands the result to the UART transmitter with a start/done handshake, then returns to waiting for the next operand A.

Parameters:
- NB_DATA, 8, width of operands, result and UART byte.
- NB_OP, 6, opcode width; taken from the low NB_OP bits of the third byte.

Ports:
- i_clock  in  1  system clock; all state changes on its rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_data  in  NB_DATA  received byte; valid only while i_rx_done=1.
- i_rx_done  in  1  one-cycle pulse from the UART RX: byte available.
- i_tx_done  in  1  one-cycle pulse from the UART TX: transmission finished.
- i_alu_result  in  NB_DATA  combinational ALU output.
- o_alu_data_a  out  NB_DATA  registered operand A to the ALU.
- o_alu_data_b  out  NB_DATA  registered operand B to the ALU.
- o_alu_op  out  NB_OP  registered opcode to the ALU.
- o_tx_data  out  NB_DATA  registered result byte to the UART TX.
- o_tx_start  out  1  one-cycle pulse requesting transmission.
- o_busy  out  1  high in COMPUTE, SEND and WAIT_TX.
- o_rx_overrun  out  1  one-cycle pulse: a byte arrived while busy and was dropped.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=WAIT_A.
  - o_alu_data_a, o_alu_data_b, o_alu_op, o_tx_data = 0.
  - o_tx_start=0, o_rx_overrun=0.
- Reset asserted mid-operation: all of the above apply immediately. A partially collected A/B/OP triplet is discarded. A pending transmission is abandoned; no o_tx_start is produced after release.
- States:
  - WAIT_A: on i_rx_done, o_alu_data_a <= i_rx_data; go to WAIT_B.
  - WAIT_B: on i_rx_done, o_alu_data_b <= i_rx_data; go to WAIT_OP.
  - WAIT_OP: on i_rx_done, o_alu_op <= i_rx_data[NB_OP-1:0]; go to COMPUTE. The upper byte bits are ignored.
  - COMPUTE: one cycle for the ALU output to settle. o_tx_data <= i_alu_result; o_tx_start <= 1; go to SEND.
  - SEND: o_tx_start is high for exactly this one cycle; go to WAIT_TX.
  - WAIT_TX: on i_tx_done, go to WAIT_A; otherwise stay. There is no timeout.
- Latency: rx_done for the opcode sampled at edge N -> COMPUTE during cycle N..N+1 -> o_tx_start high during cycle N+1..N+2 -> o_tx_data valid from edge N+1 and held until the next COMPUTE.
- Unknown opcodes are forwarded unchanged. The result is whatever the ALU produces; no validation is done here.
- Operand registers and o_alu_op hold their values between transactions. They change only on the matching rx_done.
- i_tx_done is ignored outside WAIT_TX, including a pulse coincident with the o_tx_start cycle.
- i_rx_done in COMPUTE, SEND or WAIT_TX: the byte is dropped and o_rx_overrun pulses on the following cycle. State and registers are unaffected.
- i_rx_done pulses on consecutive cycles in WAIT_A/WAIT_B: each pulse is accepted in turn, one byte per cycle.
- Simultaneous i_rx_done and i_tx_done in WAIT_TX: the tx_done transition wins, the rx byte is dropped, and o_rx_overrun pulses.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package:
  - state encoding (WAIT_A, WAIT_B, WAIT_OP, COMPUTE, SEND, WAIT_TX; 3-bit localparams).
  - ALU opcode constants, shared with the ALU and benches: ADD=32, SUB=34, AND=36, OR=37, XOR=38, SRA=3, SRL=2, NOR=39.
  - NB_DATA / NB_OP defaults.
- Single module; no sub-module is warranted. The bench instantiates it with the existing ALU and drives the rx/tx handshakes directly.

Test Plan:
- Release reset; rx bytes 8'h05, 8'h03, 8'd32 -> o_alu_data_a=5, o_alu_data_b=3, o_alu_op=32; o_tx_start pulses once, 2 cycles after the opcode rx_done; o_tx_data=8'h08; after i_tx_done, o_busy=0 and state=WAIT_A.
- Bytes 8'hF0, 8'h02, 8'd3 (SRA) -> o_tx_data=8'hFC. Repeat with 8'd2 (SRL) -> 8'h3C. Repeat with 8'd39 (NOR) on 8'hF0, 8'h0F -> 8'h00.
- Opcode byte 8'hE2 -> o_alu_op=6'd34 (SUB); with A=8'h01, B=8'h02 -> o_tx_data=8'hFF.
- Extra rx_done (byte 8'hAA) during WAIT_TX -> o_rx_overrun pulses once; o_alu_data_a unchanged; the next triplet after tx_done computes correctly.
- Assert i_reset after A and B received, before the opcode -> all outputs 0 immediately; after release, a fresh triplet 8'h02, 8'h02, 8'd36 -> o_tx_data=8'h02.
- Hold i_tx_done low for 50 cycles -> o_busy stays 1, no second o_tx_start; a tx_done pulse coincident with o_tx_start is ignored.
